// File: rtl/bitty_sequencer.sv
// bitty_sequencer: multi-cycle instruction sequencer for BittyPro.
// It fetches one instruction over a valid/ready handshake, then walks the
// datapath through operand-X load, operand-Y/ALU, writeback and retire phases.
module bitty_sequencer #(
  parameter int INST_W = 16,
  parameter int NREG   = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [INST_W-1:0] inst_in,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic              number,
  output logic              en_s,
  output logic              en_c,
  output logic [NREG-1:0]   en_rx,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  retired
);

  localparam int IDX_W = $clog2(NREG);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD_X,
    LOAD_Y,
    WRITE,
    RETIRE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic [IDX_W-1:0]  dest;

  // A transfer happens only in FETCH while the source offers a word.
  assign accept = (state == FETCH) && inst_valid;

  // Destination register index sits in the top bits of the instruction.
  assign dest = inst[INST_W-1 -: IDX_W];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an all-zero word is a NOP and skips straight to retire.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        if (accept) begin
          state_next = (inst_in == '0) ? RETIRE : LOAD_X;
        end else if (!run) begin
          state_next = IDLE;
        end
      end
      LOAD_X: state_next = LOAD_Y;
      LOAD_Y: state_next = WRITE;
      WRITE:  state_next = RETIRE;
      RETIRE: state_next = run ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Instruction register: loads on a handshake and otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst <= '0;
    end else if (accept) begin
      inst <= inst_in;
    end
  end

  // Retired-instruction counter, wrapping naturally at its width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired <= '0;
    end else if (state == RETIRE) begin
      retired <= retired + 1'b1;
    end
  end

  // Output decode from registered state and instruction only.
  always_comb begin
    inst_ready = 1'b0;
    number     = 1'b0;
    en_s       = 1'b0;
    en_c       = 1'b0;
    en_rx      = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    unique case (state)
      IDLE:   ;
      FETCH:  inst_ready = 1'b1;
      LOAD_X: begin
        number = 1'b1;
        en_s   = 1'b1;
      end
      LOAD_Y: en_c = 1'b1;
      WRITE: begin
        for (int unsigned i = 0; i < NREG; i++) begin
          en_rx[i] = (dest == i[IDX_W-1:0]);
        end
      end
      RETIRE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
